// File: rtl/hi_lo_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : hi_lo_ctrl_if
// Brief   : Request/multiplier/result bundle for the HI/LO controller.
// Revision: 1.0  initial release
// ============================================================================
interface hi_lo_ctrl_if;
  logic [5:0]  Signal;
  logic        start;
  logic [63:0] mulOut;
  logic [5:0]  mulSignal;
  logic        mulRst;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] dataOut;

  modport slave (
    input  Signal, start, mulOut,
    output mulSignal, mulRst, busy, done, hi, lo, dataOut
  );

  modport master (
    output Signal, start, mulOut,
    input  mulSignal, mulRst, busy, done, hi, lo, dataOut
  );
endinterface
`default_nettype wire

// File: rtl/hi_lo_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : hi_lo_ctrl
// Brief   : Sequences a 32-cycle MULTU on an external multiplier and owns
//           HI/LO plus the MFHI/MFLO read path. Option: HILO_BYPASS_EN.
// Revision: 1.0  initial release
// ============================================================================
module hi_lo_ctrl (
  input  logic         clk,
  input  logic         reset,
  hi_lo_ctrl_if.slave  bus
);

  localparam logic [5:0] c_MULTU      = 6'b011001;
  localparam logic [5:0] c_MFHI       = 6'b010000;
  localparam logic [5:0] c_MFLO       = 6'b010010;
  localparam logic [5:0] c_RUN_CODE   = 6'b111111;
  localparam logic [5:0] c_IDLE_CODE  = 6'b000000;
  localparam logic [5:0] c_LAST_COUNT = 6'd31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    RUN   = 2'd2,
    LATCH = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [5:0]  r_count;
  logic [5:0]  w_next_count;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_data_out;
  logic [5:0]  w_mul_signal;
  logic        w_mul_rst;
  logic        w_busy;
  logic        w_done;
  logic        w_mfhi;
  logic        w_mflo;
  logic [31:0] w_src_hi;
  logic [31:0] w_src_lo;

  always_comb begin
    w_next_state = r_state;
    w_next_count = r_count;
    w_mul_signal = c_IDLE_CODE;
    w_mul_rst    = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start && (bus.Signal == c_MULTU)) begin
          w_next_state = CLR;
        end
      end
      CLR: begin
        w_busy       = 1'b1;
        w_mul_rst    = 1'b1;
        w_mul_signal = c_MULTU;
        w_next_count = 6'd0;
        w_next_state = RUN;
      end
      RUN: begin
        w_busy       = 1'b1;
        w_mul_signal = c_RUN_CODE;
        w_next_count = r_count + 6'd1;
        if (r_count == c_LAST_COUNT) begin
          w_next_state = LATCH;
        end
      end
      LATCH: begin
        w_busy       = 1'b1;
        w_done       = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  assign w_mfhi = bus.start && (bus.Signal == c_MFHI);
  assign w_mflo = bus.start && (bus.Signal == c_MFLO);

`ifdef HILO_BYPASS_EN
  // A read landing in LATCH sees the product being written this cycle.
  assign w_src_hi = (r_state == LATCH) ? bus.mulOut[63:32] : r_hi;
  assign w_src_lo = (r_state == LATCH) ? bus.mulOut[31:0]  : r_lo;
`else
  assign w_src_hi = r_hi;
  assign w_src_lo = r_lo;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_count    <= 6'd0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
      r_data_out <= 32'd0;
    end else begin
      r_state <= w_next_state;
      r_count <= w_next_count;
      if (r_state == LATCH) begin
        r_hi <= bus.mulOut[63:32];
        r_lo <= bus.mulOut[31:0];
      end
      if (w_mfhi) begin
        r_data_out <= w_src_hi;
      end else if (w_mflo) begin
        r_data_out <= w_src_lo;
      end
    end
  end

  assign bus.mulSignal = w_mul_signal;
  assign bus.mulRst    = w_mul_rst;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.hi        = r_hi;
  assign bus.lo        = r_lo;
  assign bus.dataOut   = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_hi_lo_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_hi_lo_ctrl
// Brief   : Directed scoreboard bench for hi_lo_ctrl (honours HILO_BYPASS_EN).
// Revision: 1.0  initial release
// ============================================================================
module tb_hi_lo_ctrl;

  localparam logic [5:0] c_MULTU = 6'b011001;
  localparam logic [5:0] c_MFHI  = 6'b010000;
  localparam logic [5:0] c_MFLO  = 6'b010010;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  logic [63:0] q_prod[$];
  logic [31:0] q_data[$];

  hi_lo_ctrl_if bus();

  hi_lo_ctrl u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycle c=1 is the CLR cycle right after the accepting edge; LATCH is c=34
  // (the 35th cycle counting the accepting one).
  task automatic run_op(input string tag, input logic [63:0] prod,
                        input int inj_c, input logic [5:0] inj_code,
                        input logic [31:0] inj_exp);
    int nb, nd, dc, bad;
    logic [5:0] exp_ms;
    nb = 0; nd = 0; dc = 0; bad = 0;
    bus.mulOut = prod;
    bus.Signal = c_MULTU;
    bus.start  = 1'b1;
    q_prod.push_back(prod);
    tick();
    bus.start  = 1'b0;
    bus.Signal = 6'd0;
    for (int c = 1; c <= 40; c++) begin
      exp_ms = (c == 1) ? 6'b011001 : ((c <= 33) ? 6'b111111 : 6'b000000);
      if (bus.mulSignal !== exp_ms || bus.mulRst !== (c == 1)) bad++;
      if (bus.busy === 1'b1) nb++;
      if (bus.done === 1'b1) begin nd++; dc = c; end
      if (c == inj_c + 1 && (inj_code == c_MFHI || inj_code == c_MFLO))
        check({tag, "_mfread"}, {32'd0, bus.dataOut}, {32'd0, q_data.pop_front()});
      if (c == inj_c) begin
        bus.Signal = inj_code;
        bus.start  = 1'b1;
        if (inj_code == c_MFHI || inj_code == c_MFLO) q_data.push_back(inj_exp);
      end else begin
        bus.start  = 1'b0;
        bus.Signal = 6'd0;
      end
      tick();
    end
    check({tag, "_mulsig_seq"}, 64'(bad), 64'd0);
    check({tag, "_busy_cycles"}, 64'(nb), 64'd34);
    check({tag, "_done_count"}, 64'(nd), 64'd1);
    check({tag, "_done_cycle"}, 64'(dc), 64'd34);
    check({tag, "_hilo"}, {bus.hi, bus.lo}, q_prod.pop_front());
  endtask

  initial begin
    int nd;
    errors = 0;
    checks = 0;
    reset      = 1'b0;
    bus.Signal = 6'd0;
    bus.start  = 1'b0;
    bus.mulOut = 64'd0;
    tick(); tick();
    check("rst_hi",        {32'd0, bus.hi},      64'd0);
    check("rst_lo",        {32'd0, bus.lo},      64'd0);
    check("rst_dataOut",   {32'd0, bus.dataOut}, 64'd0);
    check("rst_busy",      {63'd0, bus.busy},    64'd0);
    check("rst_done",      {63'd0, bus.done},    64'd0);
    check("rst_mulRst",    {63'd0, bus.mulRst},  64'd0);
    check("rst_mulSignal", {58'd0, bus.mulSignal}, 64'd0);
    reset = 1'b1;

    run_op("mul3x5", 64'd15, -5, 6'd0, 32'd0);

    run_op("mulmax", 64'hFFFFFFFE_00000001, -5, 6'd0, 32'd0);
    bus.Signal = c_MFHI; bus.start = 1'b1; q_data.push_back(32'hFFFFFFFE);
    tick();
    bus.start = 1'b0; bus.Signal = 6'd0;
    check("mfhi_idle", {32'd0, bus.dataOut}, {32'd0, q_data.pop_front()});
    bus.Signal = c_MFLO; bus.start = 1'b1; q_data.push_back(32'h00000001);
    tick();
    bus.start = 1'b0; bus.Signal = 6'd0;
    check("mflo_idle", {32'd0, bus.dataOut}, {32'd0, q_data.pop_front()});

    // Non-MULTU/MF codes and start=0 leave everything alone.
    bus.Signal = 6'h3F; bus.start = 1'b1;
    tick();
    bus.Signal = c_MULTU; bus.start = 1'b0;
    tick();
    bus.Signal = 6'd0;
    check("noop_busy",    {63'd0, bus.busy},    64'd0);
    check("noop_dataOut", {32'd0, bus.dataOut}, 64'd1);
    check("noop_hilo",    {bus.hi, bus.lo},     64'hFFFFFFFE_00000001);

    run_op("lo7", 64'd7, -5, 6'd0, 32'd0);
    // MFLO during RUN count 10 (c=12) returns the pre-multiply lo.
    run_op("mflo_run", 64'd7, 12, c_MFLO, 32'd7);
`ifdef HILO_BYPASS_EN
    run_op("mflo_latch", 64'd9, 34, c_MFLO, 32'd9);
`else
    run_op("mflo_latch", 64'd9, 34, c_MFLO, 32'd7);
`endif

    // Second MULTU at RUN count 10 must be dropped.
    run_op("dup_multu", 64'h00001234_00005678, 12, c_MULTU, 32'd0);

    // Reset asserted at RUN count 20 (c=22), away from a clock edge.
    bus.mulOut = 64'hDEAD_BEEF_CAFE_F00D;
    bus.Signal = c_MULTU; bus.start = 1'b1;
    q_prod.push_back(bus.mulOut);
    tick();
    bus.start = 1'b0; bus.Signal = 6'd0;
    for (int c = 1; c < 22; c++) tick();
    check("pre_abort_busy", {63'd0, bus.busy}, 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("abort_outputs_zero",
          {bus.hi, bus.lo} | {bus.dataOut, 32'd0} |
          {57'd0, bus.busy, bus.done, bus.mulRst, 4'd0} | {58'd0, bus.mulSignal},
          64'd0);
    void'(q_prod.pop_back());
    nd = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (bus.done === 1'b1) nd++;
    end
    reset = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.done === 1'b1) nd++;
    end
    check("abort_no_done", 64'(nd), 64'd0);
    check("abort_hilo", {bus.hi, bus.lo}, 64'd0);

    run_op("post_reset", 64'hABCD0000_00001111, -5, 6'd0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hi_lo_ctrl.md
HI_LO_CTRL -- requirements
Module: hi_lo_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have port: Signal  input  6  funct code: MULTU=6'b011001, MFHI=6'b010000, MFLO=6'b010010; other codes are no-ops.
REQ-004 SHALL have port: start  input  1  request valid for Signal, sampled on each rising clk.
REQ-005 SHALL have port: mulOut  input  64  product from downstream multiplier.
REQ-006 SHALL have port: mulSignal  output  6  function code driven to multiplier.
REQ-007 SHALL have port: mulRst  output  1  active-high clear to multiplier accumulator.
REQ-008 SHALL have port: busy  output  1  high while a multiply is in flight.
REQ-009 SHALL have port: done  output  1  one-cycle pulse when HI/LO are written.
REQ-010 SHALL have port: hi, lo  output  32 each  architectural HI/LO registers.
REQ-011 SHALL have port: dataOut  output  32  registered MFHI/MFLO result.

Function
REQ-012 SHALL implement FSM states IDLE, CLR, RUN, LATCH.
REQ-013 IDLE: start=1 with Signal=MULTU SHALL move to CLR; busy rises the following cycle.
REQ-014 CLR (1 cycle): mulRst=1, mulSignal=6'b011001; next state RUN with 6-bit counter loaded to 0.
REQ-015 RUN: mulSignal=6'b111111 for exactly 32 cycles, counter incrementing 0..31; at count 31 next state LATCH.
REQ-016 LATCH (1 cycle): {hi,lo} <= mulOut at end of cycle; done=1; next state IDLE.
REQ-017 mulSignal SHALL be 6'b000000 and mulRst 0 in IDLE and LATCH.
REQ-018 busy SHALL be 1 in CLR, RUN, LATCH; latency from start acceptance to done = 35 cycles (1 CLR + 32 RUN + LATCH on cycle 35).
REQ-019 start with MULTU while busy SHALL be ignored (not queued); current operation unaffected.
REQ-020 start with MFHI/MFLO in any state SHALL load dataOut with hi/lo one cycle later; dataOut holds otherwise.
REQ-021 MFHI/MFLO while busy (except LATCH, see REQ-027) SHALL return the pre-multiply HI/LO values.
REQ-022 Signal codes other than the three listed, or start=0, SHALL change no state.
REQ-023 Product width: hi = mulOut[63:32], lo = mulOut[31:0], no truncation or sign handling.

Reset
REQ-024 reset=0 SHALL asynchronously force state IDLE, counter 0, hi=0, lo=0, dataOut=0, busy=0, done=0, mulRst=0, mulSignal=6'b000000.
REQ-025 reset asserted mid-RUN SHALL abort the multiply; HI/LO return 0 and no done pulse is produced.
REQ-026 After reset deassertion, first MULTU request SHALL be accepted on the next rising edge.

Configuration
REQ-027 Macro HILO_BYPASS_EN: when defined, MFHI/MFLO sampled in LATCH SHALL load dataOut from mulOut[63:32]/mulOut[31:0] (new product); when undefined, SHALL load from current hi/lo (old values).

Verification
REQ-028 Reset, MULTU with multiplier product 64'd15 (3*5) -> busy for 34 cycles, done at cycle 35, hi=0, lo=32'd15.
REQ-029 MULTU with mulOut=64'hFFFFFFFE_00000001 (0xFFFFFFFF squared) -> hi=32'hFFFFFFFE, lo=32'h00000001; MFHI then dataOut=32'hFFFFFFFE next cycle.
REQ-030 Second MULTU issued at RUN count 10 -> ignored; done pulses exactly once, at original cycle 35.
REQ-031 reset=0 at RUN count 20 -> all outputs zero immediately (asynchronously), no done; new MULTU after release completes normally.
REQ-032 Prior lo=7, product lo=9, MFLO in LATCH -> dataOut=9 with HILO_BYPASS_EN, 7 without.
REQ-033 MFLO during RUN with lo=7 -> dataOut=7; mulSignal stays 6'b111111, counter unaffected.
